// File: rtl/orpsoc_pkg.sv
// Shared definitions for the orpsoc simulation top: JTAG opcodes, TAP states
// and the layout of the memory-access data register.
package orpsoc_pkg;

   localparam logic [3:0] IDCODE_IR = 4'h1;
   localparam logic [3:0] MEMACC_IR = 4'h8;
   localparam logic [3:0] BYPASS_IR = 4'hF;

   localparam logic [3:0] IR_CAPTURE = 4'b0101;

   localparam int unsigned MEMACC_DR_W = 65;
   localparam int unsigned DR_DATA_LSB = 0;
   localparam int unsigned DR_ADDR_LSB = 32;
   localparam int unsigned DR_WE_BIT   = 64;

   localparam logic [31:0] DEFAULT_IDCODE = 32'h14951185;

   typedef enum logic [3:0] {
      TLR, RTI,
      SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
      SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
   } tap_state_e;

endpackage

// File: rtl/orpsoc_if.sv
// Classic single-port Wishbone bus between the JTAG access master and the RAM.
interface orpsoc_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [3:0]  sel;
   logic [31:0] adr;
   logic [31:0] dat_w;
   logic [31:0] dat_r;
   logic        ack;

   modport master (output cyc, stb, we, sel, adr, dat_w, input  dat_r, ack);
   modport slave  (input  cyc, stb, we, sel, adr, dat_w, output dat_r, ack);
endinterface

// File: rtl/orpsoc_wb_ram.sv
// Wishbone RAM of MEM_SIZE bytes; contents survive reset and may be loaded
// from outside through ram0.mem.
module wb_ram
   import orpsoc_pkg::*;
#(
   parameter logic [31:0] MEM_SIZE = 32'h02000000
) (
   input  logic     clk_i,
   input  logic     rst_i,
   orpsoc_if.slave  wb
);

   localparam int unsigned AW    = $clog2(MEM_SIZE);
   localparam int unsigned DEPTH = MEM_SIZE / 4;

   logic [AW-3:0] idx;
   logic [31:0]   rd_word;
   logic          req;
   logic          ack_q;
   logic [31:0]   dat_q;
   logic          unused_adr;

   // Address bits above the RAM size are dropped so accesses wrap.
   assign idx        = wb.adr[AW-1:2];
   assign unused_adr = ^{wb.adr[31:AW], wb.adr[1:0]};
   assign req        = wb.cyc & wb.stb & ~ack_q;

   if (1) begin : ram0
      logic [31:0] mem [0:DEPTH-1];

      always_ff @(posedge clk_i) begin
         if (!rst_i && req && wb.we) begin
            for (int unsigned i = 0; i < 4; i++) begin
               if (wb.sel[i]) mem[idx][8*i +: 8] <= wb.dat_w[8*i +: 8];
            end
         end
      end

      assign rd_word = mem[idx];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ack_q <= 1'b0;
         dat_q <= '0;
      end else begin
         ack_q <= req;
         if (req) dat_q <= rd_word;
      end
   end

   assign wb.ack   = ack_q;
   assign wb.dat_r = dat_q;

endmodule

// File: rtl/orpsoc.sv
// orpsoc_top: reset synchroniser, JTAG TAP and a memory-access DR that masters
// the Wishbone RAM across the tck / wb_clk boundary via toggle handshakes.
module orpsoc_top
   import orpsoc_pkg::*;
#(
   parameter logic [31:0] MEM_SIZE = 32'h02000000,
   parameter logic [31:0] IDCODE   = DEFAULT_IDCODE
) (
   input  logic wb_clk_i,
   input  logic wb_rst_i,
   input  logic tck_pad_i,
   input  logic tms_pad_i,
   input  logic tdi_pad_i,
   output logic tdo_pad_o
);

   logic [1:0]  rst_sync_q;
   logic        wb_rst;

   tap_state_e  state_q, state_d;
   logic        in_tlr, cap_ir, sh_ir, upd_ir, cap_dr, sh_dr, upd_dr;
   logic [3:0]  ir_q, ir_sr_q;
   logic [31:0] idcode_sr_q;
   logic        bypass_q;
   logic [MEMACC_DR_W-1:0] memacc_sr_q;
   logic        tdo_d, tdo_q;

   logic        req_tgl_q, started_q, pending, done;
   logic        req_we_q;
   logic [31:0] req_adr_q, req_dat_q;
   logic [1:0]  ack_sync_q;

   logic [1:0]  req_sync_q;
   logic        ack_tgl_q, cyc_q;
   logic [31:0] acc_dat_q;

   orpsoc_if wb_bus ();

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) rst_sync_q <= '0;
      else           rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign wb_rst = ~rst_sync_q[1];

   always_ff @(posedge tck_pad_i or negedge wb_rst_i) begin
      if (!wb_rst_i) state_q <= TLR;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         TLR:    state_d = tms_pad_i ? TLR    : RTI;
         RTI:    state_d = tms_pad_i ? SEL_DR : RTI;
         SEL_DR: state_d = tms_pad_i ? SEL_IR : CAP_DR;
         CAP_DR: state_d = tms_pad_i ? EX1_DR : SH_DR;
         SH_DR:  state_d = tms_pad_i ? EX1_DR : SH_DR;
         EX1_DR: state_d = tms_pad_i ? UPD_DR : PA_DR;
         PA_DR:  state_d = tms_pad_i ? EX2_DR : PA_DR;
         EX2_DR: state_d = tms_pad_i ? UPD_DR : SH_DR;
         UPD_DR: state_d = tms_pad_i ? SEL_DR : RTI;
         SEL_IR: state_d = tms_pad_i ? TLR    : CAP_IR;
         CAP_IR: state_d = tms_pad_i ? EX1_IR : SH_IR;
         SH_IR:  state_d = tms_pad_i ? EX1_IR : SH_IR;
         EX1_IR: state_d = tms_pad_i ? UPD_IR : PA_IR;
         PA_IR:  state_d = tms_pad_i ? EX2_IR : PA_IR;
         EX2_IR: state_d = tms_pad_i ? UPD_IR : SH_IR;
         UPD_IR: state_d = tms_pad_i ? SEL_DR : RTI;
      endcase
   end

   always_comb begin
      in_tlr = (state_q == TLR);
      cap_ir = (state_q == CAP_IR);
      sh_ir  = (state_q == SH_IR);
      upd_ir = (state_q == UPD_IR);
      cap_dr = (state_q == CAP_DR);
      sh_dr  = (state_q == SH_DR);
      upd_dr = (state_q == UPD_DR);
   end

   assign pending = req_tgl_q ^ ack_sync_q[1];
   assign done    = started_q & ~pending;

   always_ff @(posedge tck_pad_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         ir_q        <= IDCODE_IR;
         ir_sr_q     <= '0;
         idcode_sr_q <= '0;
         bypass_q    <= 1'b0;
         memacc_sr_q <= '0;
         req_tgl_q   <= 1'b0;
         started_q   <= 1'b0;
         req_we_q    <= 1'b0;
         req_adr_q   <= '0;
         req_dat_q   <= '0;
         ack_sync_q  <= '0;
      end else begin
         ack_sync_q <= {ack_sync_q[0], ack_tgl_q};

         if (in_tlr)      ir_q <= IDCODE_IR;
         else if (upd_ir) ir_q <= ir_sr_q;

         if (cap_ir)     ir_sr_q <= IR_CAPTURE;
         else if (sh_ir) ir_sr_q <= {tdi_pad_i, ir_sr_q[3:1]};

         unique case (ir_q)
            IDCODE_IR: begin
               if (cap_dr)     idcode_sr_q <= IDCODE;
               else if (sh_dr) idcode_sr_q <= {tdi_pad_i, idcode_sr_q[31:1]};
            end
            MEMACC_IR: begin
               // Address field is left alone on capture so a poll can re-read it.
               if (cap_dr)
                  memacc_sr_q <= {done, memacc_sr_q[DR_ADDR_LSB +: 32], acc_dat_q};
               else if (sh_dr)
                  memacc_sr_q <= {tdi_pad_i, memacc_sr_q[MEMACC_DR_W-1:1]};
               if (upd_dr && !pending) begin
                  req_tgl_q <= ~req_tgl_q;
                  started_q <= 1'b1;
                  req_we_q  <= memacc_sr_q[DR_WE_BIT];
                  req_adr_q <= memacc_sr_q[DR_ADDR_LSB +: 32];
                  req_dat_q <= memacc_sr_q[DR_DATA_LSB +: 32];
               end
            end
            default: begin
               if (cap_dr)     bypass_q <= 1'b0;
               else if (sh_dr) bypass_q <= tdi_pad_i;
            end
         endcase
      end
   end

   always_comb begin
      tdo_d = 1'b0;
      if (sh_ir) begin
         tdo_d = ir_sr_q[0];
      end else if (sh_dr) begin
         unique case (ir_q)
            IDCODE_IR: tdo_d = idcode_sr_q[0];
            MEMACC_IR: tdo_d = memacc_sr_q[0];
            default:   tdo_d = bypass_q;
         endcase
      end
   end

   always_ff @(negedge tck_pad_i or negedge wb_rst_i) begin
      if (!wb_rst_i) tdo_q <= 1'b0;
      else           tdo_q <= tdo_d;
   end
   assign tdo_pad_o = tdo_q;

   // Request fields are held stable by the pending guard, so wb side reads them directly.
   always_ff @(posedge wb_clk_i or posedge wb_rst) begin
      if (wb_rst) begin
         req_sync_q <= '0;
         ack_tgl_q  <= 1'b0;
         cyc_q      <= 1'b0;
         acc_dat_q  <= '0;
      end else begin
         req_sync_q <= {req_sync_q[0], req_tgl_q};
         if (cyc_q && wb_bus.ack) begin
            cyc_q     <= 1'b0;
            ack_tgl_q <= ~ack_tgl_q;
            acc_dat_q <= req_we_q ? req_dat_q : wb_bus.dat_r;
         end else if (!cyc_q && (req_sync_q[1] != ack_tgl_q)) begin
            cyc_q <= 1'b1;
         end
      end
   end

   assign wb_bus.cyc   = cyc_q;
   assign wb_bus.stb   = cyc_q;
   assign wb_bus.we    = req_we_q;
   assign wb_bus.sel   = 4'hF;
   assign wb_bus.adr   = req_adr_q;
   assign wb_bus.dat_w = req_dat_q;

   wb_ram #(
      .MEM_SIZE(MEM_SIZE)
   ) wb_bfm_memory0 (
      .clk_i(wb_clk_i),
      .rst_i(wb_rst),
      .wb   (wb_bus)
   );

endmodule

// File: tb/tb_orpsoc_top.sv
// Directed bench for orpsoc_top: reset sync, IDCODE, BYPASS, JTAG memory
// access, address wrap and reset during a pending access.
module tb_orpsoc_top;
   import orpsoc_pkg::*;

   logic wb_clk = 1'b0;
   logic wb_rst_n;
   logic tck_pad, tms_pad, tdi_pad;
   logic tdo_pad;

   int applied     = 0;
   int miscompares = 0;

   orpsoc_top #(
      .MEM_SIZE(32'h1000),
      .IDCODE  (32'h14951185)
   ) dut (
      .wb_clk_i (wb_clk),
      .wb_rst_i (wb_rst_n),
      .tck_pad_i(tck_pad),
      .tms_pad_i(tms_pad),
      .tdi_pad_i(tdi_pad),
      .tdo_pad_o(tdo_pad)
   );

   always #5 wb_clk = ~wb_clk;

   task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      applied++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One tck period: tdo is sampled before the rising edge, then tck rises and falls.
   task automatic tick(input logic tms, input logic tdi, output logic tdo);
      #5;
      tdo     = tdo_pad;
      tms_pad = tms;
      tdi_pad = tdi;
      #15 tck_pad = 1'b1;
      #20 tck_pad = 1'b0;
   endtask

   task automatic idle(input int unsigned n);
      logic b;
      for (int unsigned i = 0; i < n; i++) tick(1'b0, 1'b0, b);
   endtask

   task automatic shift_ir(input logic [3:0] v, output logic [3:0] o);
      logic b;
      tick(1'b1, 1'b0, b);
      tick(1'b1, 1'b0, b);
      tick(1'b0, 1'b0, b);
      tick(1'b0, 1'b0, b);
      for (int unsigned i = 0; i < 4; i++) begin
         tick(i == 3, v[i], b);
         o[i] = b;
      end
      tick(1'b1, 1'b0, b);
      tick(1'b0, 1'b0, b);
   endtask

   // With hold set, returns with tck high right after the Update-DR edge.
   task automatic shift_dr(input int unsigned n, input logic [64:0] din, input bit hold,
                           output logic [64:0] dout);
      logic b;
      dout = '0;
      tick(1'b1, 1'b0, b);
      tick(1'b0, 1'b0, b);
      tick(1'b0, 1'b0, b);
      for (int unsigned i = 0; i < n; i++) begin
         tick(i == n - 1, din[i], b);
         dout[i] = b;
      end
      tick(1'b1, 1'b0, b);
      if (hold) begin
         #5 tms_pad = 1'b0;
         #15 tck_pad = 1'b1;
      end else begin
         tick(1'b0, 1'b0, b);
      end
   endtask

   initial begin
      logic [64:0] dout;
      logic [3:0]  irout;
      logic        b;
      bit          found;

      wb_rst_n = 1'b0;
      tck_pad  = 1'b0;
      tms_pad  = 1'b1;
      tdi_pad  = 1'b0;

      #100;
      check("rst_held", dut.wb_rst, 1'b1);
      check("tdo_in_reset", tdo_pad, 1'b0);
      @(negedge wb_clk);
      wb_rst_n = 1'b1;
      @(posedge wb_clk);
      #1 check("rst_after_edge1", dut.wb_rst, 1'b1);
      @(posedge wb_clk);
      #1 check("rst_after_edge2", dut.wb_rst, 1'b0);

      for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, b);
      tick(1'b0, 1'b0, b);
      #6 check("tdo_idle", tdo_pad, 1'b0);

      shift_dr(32, 65'h0, 1'b0, dout);
      check("idcode", dout[31:0], 32'h14951185);

      shift_ir(BYPASS_IR, irout);
      check("ir_capture", irout, 4'b0101);
      shift_dr(9, {56'h0, 1'b0, 8'b10110011}, 1'b0, dout);
      check("bypass", dout[8:0], {8'b10110011, 1'b0});

      shift_ir(MEMACC_IR, irout);
      shift_dr(65, {1'b1, 32'h0000_0100, 32'hDEAD_BEEF}, 1'b0, dout);
      idle(8);
      check("mem_write", dut.wb_bfm_memory0.ram0.mem[64], 32'hDEAD_BEEF);

      shift_dr(65, {1'b0, 32'h0000_0100, 32'h0}, 1'b0, dout);
      check("capture_after_write", dout, {1'b1, 32'h0000_0100, 32'hDEAD_BEEF});
      idle(8);
      shift_dr(65, {1'b0, 32'h0000_0100, 32'h0}, 1'b0, dout);
      check("read_back", dout, {1'b1, 32'h0000_0100, 32'hDEAD_BEEF});
      idle(8);

      dut.wb_bfm_memory0.ram0.mem[0] = 32'hCAFE_F00D;
      shift_dr(65, {1'b0, 32'h0000_1000, 32'h0}, 1'b0, dout);
      idle(8);
      shift_dr(65, {1'b0, 32'h0000_1000, 32'h0}, 1'b0, dout);
      check("wrap_read", dout, {1'b1, 32'h0000_1000, 32'hCAFE_F00D});
      idle(8);

      shift_dr(65, {1'b0, 32'h0000_0100, 32'h0}, 1'b1, dout);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge wb_clk);
         if (dut.wb_bus.cyc === 1'b1) found = 1'b1;
      end
      check("cyc_seen", found, 1'b1);
      wb_rst_n = 1'b0;
      #1;
      check("cyc_abort", dut.wb_bus.cyc, 1'b0);
      check("tap_tlr", dut.state_q, TLR);
      check("ir_idcode", dut.ir_q, IDCODE_IR);
      check("tdo_abort", tdo_pad, 1'b0);
      #19 tck_pad = 1'b0;
      #80;
      @(negedge wb_clk);
      wb_rst_n = 1'b1;
      repeat (3) @(posedge wb_clk);
      #1 check("mem_kept", dut.wb_bfm_memory0.ram0.mem[64], 32'hDEAD_BEEF);

      tick(1'b0, 1'b0, b);
      shift_ir(MEMACC_IR, irout);
      shift_dr(65, 65'h0, 1'b0, dout);
      check("done_after_reset", dout[64], 1'b0);
      idle(8);

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule

// File: doc/orpsoc_top.md
Name: orpsoc_top

Overview:
Minimal simulation SoC top. Contains a reset synchroniser, a Wishbone single-port RAM of MEM_SIZE bytes (`wb_bfm_memory0`), and a JTAG TAP whose memory-access data register masters the Wishbone bus.
- The testbench supplies clock and reset and may backdoor-load RAM through the hierarchy.
- The CPU core and its trace monitor are outside this block.

Parameters:
- MEM_SIZE, 32'h02000000, RAM size in bytes. Power of two, at least 8.
- IDCODE, 32'h14951185, value captured by the IDCODE instruction.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  asynchronous, active-low system reset.
- tck_pad_i  in  1  JTAG test clock, asynchronous to wb_clk_i.
- tms_pad_i  in  1  JTAG mode select, sampled on rising tck.
- tdi_pad_i  in  1  JTAG data in, sampled on rising tck.
- tdo_pad_o  out  1  JTAG data out, changes on falling tck. 0 outside Shift-IR/Shift-DR.

Behaviour:
- Internal signal `wb_rst` (active-high, fixed name, referenced hierarchically):
  - asserts asynchronously when wb_rst_i=0;
  - deasserts on the 2nd rising wb_clk_i after wb_rst_i rises (2-flop synchroniser).
  - All wb-domain flops reset on wb_rst.
- TAP state machine:
  - Standard 16-state IEEE 1149.1 TAP on tck.
  - Reset to Test-Logic-Reset asynchronously while wb_rst_i=0; also reaches it after 5 tck with tms=1.
  - IR is 4 bits, loaded with IDCODE (4'h1) in Test-Logic-Reset. Capture-IR loads 4'b0101.
  - Instructions: 4'h1 IDCODE (32-bit DR); 4'h8 MEMACC (65-bit DR); 4'hF BYPASS and all others (1-bit DR, captures 0).
  - All shifts are LSB first. tdo is the LSB of the selected register, registered on falling tck.
- MEMACC DR layout: [31:0] data, [63:32] byte address, [64] we.
  - Capture-DR: [31:0] ← last completed access data (read data, or write data for writes); [63:32] unchanged; [64] ← done flag.
  - Update-DR:
    - toggles a request flag (tck domain), clears done, and latches we/addr/data.
    - Request reaches the wb domain through a 2-flop toggle synchroniser.
    - wb side then asserts cyc=stb=1 with sel=4'hF until ack.
    - Ack sets a done toggle, synchronised back to tck (2 flops).
  - Host must wait at least 6 tck plus 4 wb_clk_i periods before the next Capture-DR.
  - An Update-DR while an access is pending is ignored.
- RAM (`wb_bfm_memory0`, array `ram0.mem[0:MEM_SIZE/4-1]`, 32-bit words):
  - Index = adr[log2(MEM_SIZE)-1:2]; upper address bits are ignored (wrap).
  - Classic Wishbone: ack pulses high for exactly 1 cycle, one cycle after cyc&stb. No back-to-back ack.
  - Write honours sel byte lanes. Read data is valid with ack.
  - Reset does not alter RAM contents. Initial contents are undefined; backdoor writes via hierarchy must be honoured.
- Reset mid-access: wb_rst aborts cyc/stb immediately; tck-side done stays 0 until the next request.

Decomposition:
- Package `orpsoc_pkg`: IR opcodes (IDCODE_IR, MEMACC_IR, BYPASS_IR), TAP state enum, MEMACC DR width and field offsets, default IDCODE.
- Sub-modules:
  - `wb_ram`, instantiated as `wb_bfm_memory0` with inner array instance `ram0`.
  - Optional `jtag_tap` holding the state machine, IR and tdo logic.
- Top contains the reset synchroniser, the MEMACC DR and the CDC handshake.

Test Plan:
- Reset: hold wb_rst_i=0 for 100 ns, release → `wb_rst` falls exactly 2 wb_clk_i rising edges later; tdo_pad_o=0.
- IDCODE: tms=1×5, navigate to Shift-DR, shift 32 bits → tdo yields 32'h14951185 LSB first.
- BYPASS: load IR 4'hF, shift 8'b10110011 through DR → same pattern appears delayed by 1 tck.
- JTAG write then read:
  - MEMACC write we=1, addr=32'h100, data=32'hDEADBEEF → mem[64]=32'hDEADBEEF.
  - Read we=0 addr=32'h100, then Capture/Shift → data field 32'hDEADBEEF, bit64=1.
- Wrap: backdoor mem[0]=32'hCAFEF00D, read addr=MEM_SIZE → returns 32'hCAFEF00D.
- Reset mid-access: assert wb_rst_i=0 during a pending access → cyc=0 immediately; TAP returns to Test-Logic-Reset; IR=IDCODE.
